// File: rtl/tcp_client_sender.sv
// Active-open TCP traffic source: opens a session to a configured IP:port, streams
// deterministic payload packets through the stack tx path, then closes the session.
module tcp_client_sender #(
    parameter logic [31:0] OPEN_TIMEOUT = 32'd1000000,
    parameter logic [15:0] RETRY_GAP    = 16'd64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  cfg_ip_addr,
    input  logic [15:0]  cfg_port,
    input  logic [15:0]  cfg_pkt_count,
    input  logic [9:0]   cfg_pkt_words,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [1:0]   err_code,
    output logic         m_axis_open_connection_TVALID,
    input  logic         m_axis_open_connection_TREADY,
    output logic [47:0]  m_axis_open_connection_TDATA,
    input  logic         s_axis_open_status_TVALID,
    output logic         s_axis_open_status_TREADY,
    input  logic [23:0]  s_axis_open_status_TDATA,
    output logic         m_axis_close_connection_TVALID,
    input  logic         m_axis_close_connection_TREADY,
    output logic [15:0]  m_axis_close_connection_TDATA,
    output logic         m_axis_tx_metadata_TVALID,
    input  logic         m_axis_tx_metadata_TREADY,
    output logic [31:0]  m_axis_tx_metadata_TDATA,
    input  logic         s_axis_tx_status_TVALID,
    output logic         s_axis_tx_status_TREADY,
    input  logic [63:0]  s_axis_tx_status_TDATA,
    output logic         m_axis_tx_data_TVALID,
    input  logic         m_axis_tx_data_TREADY,
    output logic [511:0] m_axis_tx_data_TDATA,
    output logic [63:0]  m_axis_tx_data_TKEEP,
    output logic         m_axis_tx_data_TLAST
);

    typedef enum logic [3:0] {
        S_IDLE, S_OPEN_REQ, S_OPEN_WAIT, S_META, S_STATUS_WAIT,
        S_RETRY, S_DATA, S_CLOSE, S_DONE, S_ERROR
    } state_t;

    // Retry re-issues metadata RETRY_GAP cycles after the "no space" status beat.
    localparam logic [31:0] TIMEOUT_LAST = (OPEN_TIMEOUT != 32'd0) ? OPEN_TIMEOUT - 32'd1 : 32'd0;
    localparam logic [31:0] RETRY_LAST   = (RETRY_GAP > 16'd1) ? {16'd0, RETRY_GAP - 16'd2} : 32'd0;

    state_t        state, state_next;
    logic [1:0]    err_code_next;
    logic [31:0]   ip_q;
    logic [15:0]   port_q;
    logic [15:0]   pkt_count_q;
    logic [9:0]    pkt_words_q;
    logic [15:0]   session_q;
    logic [31:0]   wait_cnt;
    logic [9:0]    beat_cnt;
    logic [31:0]   beat_idx;
    logic [15:0]   pkt_cnt;

    logic open_hs, meta_hs, data_hs, close_hs, open_st_hs, tx_st_hs, last_beat;
    logic [1:0] tx_err;
    logic unused_status_bits;

    assign open_hs    = m_axis_open_connection_TVALID && m_axis_open_connection_TREADY;
    assign meta_hs    = m_axis_tx_metadata_TVALID && m_axis_tx_metadata_TREADY;
    assign data_hs    = m_axis_tx_data_TVALID && m_axis_tx_data_TREADY;
    assign close_hs   = m_axis_close_connection_TVALID && m_axis_close_connection_TREADY;
    assign open_st_hs = s_axis_open_status_TVALID && s_axis_open_status_TREADY;
    assign tx_st_hs   = s_axis_tx_status_TVALID && s_axis_tx_status_TREADY;
    assign tx_err     = s_axis_tx_status_TDATA[63:62];
    assign last_beat  = (beat_cnt == pkt_words_q - 10'd1);

    assign unused_status_bits = ^{s_axis_open_status_TDATA[23:17], s_axis_tx_status_TDATA[61:0]};

    assign s_axis_open_status_TREADY = (state == S_OPEN_WAIT);
    assign s_axis_tx_status_TREADY   = (state == S_STATUS_WAIT);

    assign m_axis_open_connection_TDATA  = {port_q, ip_q};
    assign m_axis_close_connection_TDATA = session_q;
    assign m_axis_tx_metadata_TDATA      = {pkt_words_q, 6'd0, session_q};
    assign m_axis_tx_data_TDATA          = {16{beat_idx}};
    assign m_axis_tx_data_TKEEP          = '1;
    assign m_axis_tx_data_TLAST          = m_axis_tx_data_TVALID && last_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        err_code_next = 2'd0;
        case (state)
            S_IDLE:      if (start) state_next = S_OPEN_REQ;
            S_OPEN_REQ:  if (open_hs) state_next = S_OPEN_WAIT;
            S_OPEN_WAIT: begin
                if (open_st_hs) begin
                    if (s_axis_open_status_TDATA[16])
                        state_next = (pkt_count_q == 16'd0) ? S_CLOSE : S_META;
                    else begin
                        state_next    = S_ERROR;
                        err_code_next = 2'd1;
                    end
                end else if (wait_cnt >= TIMEOUT_LAST) begin
                    state_next    = S_ERROR;
                    err_code_next = 2'd2;
                end
            end
            S_META:        if (meta_hs) state_next = S_STATUS_WAIT;
            S_STATUS_WAIT: begin
                if (tx_st_hs) begin
                    case (tx_err)
                        2'd0:    state_next = S_DATA;
                        2'd2:    state_next = S_RETRY;
                        default: begin
                            state_next    = S_ERROR;
                            err_code_next = 2'd3;
                        end
                    endcase
                end
            end
            S_RETRY: if (wait_cnt >= RETRY_LAST) state_next = S_META;
            S_DATA: begin
                if (data_hs && last_beat)
                    state_next = (pkt_cnt + 16'd1 == pkt_count_q) ? S_CLOSE : S_META;
            end
            S_CLOSE: if (close_hs) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_ERROR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: every TVALID is a flop loaded from state_next, so it rises in the same
    // cycle the FSM enters the issuing state and holds until that state is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_open_connection_TVALID  <= 1'b0;
            m_axis_tx_metadata_TVALID      <= 1'b0;
            m_axis_tx_data_TVALID          <= 1'b0;
            m_axis_close_connection_TVALID <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
            ip_q        <= '0;
            port_q      <= '0;
            pkt_count_q <= '0;
            pkt_words_q <= '0;
            session_q   <= '0;
            wait_cnt    <= '0;
            beat_cnt    <= '0;
            beat_idx    <= '0;
            pkt_cnt     <= '0;
        end else begin
            m_axis_open_connection_TVALID  <= (state_next == S_OPEN_REQ);
            m_axis_tx_metadata_TVALID      <= (state_next == S_META);
            m_axis_tx_data_TVALID          <= (state_next == S_DATA);
            m_axis_close_connection_TVALID <= (state_next == S_CLOSE);
            done <= (state_next == S_DONE);

            if (state == S_IDLE && start) begin
                ip_q        <= cfg_ip_addr;
                port_q      <= cfg_port;
                pkt_count_q <= cfg_pkt_count;
                pkt_words_q <= (cfg_pkt_words == 10'd0) ? 10'd1 : cfg_pkt_words;
                error       <= 1'b0;
                err_code    <= 2'd0;
                busy        <= 1'b1;
                beat_idx    <= '0;
                pkt_cnt     <= '0;
            end

            if (state_next == S_DONE || state_next == S_ERROR) busy <= 1'b0;
            if (state_next == S_ERROR) begin
                error    <= 1'b1;
                err_code <= err_code_next;
            end

            if (open_st_hs && s_axis_open_status_TDATA[16]) session_q <= s_axis_open_status_TDATA[15:0];

            if (state_next != state)
                wait_cnt <= '0;
            else if (state == S_OPEN_WAIT || state == S_RETRY)
                wait_cnt <= wait_cnt + 32'd1;

            if (tx_st_hs && tx_err == 2'd0) beat_cnt <= '0;
            if (data_hs) begin
                beat_idx <= beat_idx + 32'd1;
                if (last_beat) begin
                    beat_cnt <= '0;
                    pkt_cnt  <= pkt_cnt + 16'd1;
                end else begin
                    beat_cnt <= beat_cnt + 10'd1;
                end
            end
        end
    end

endmodule

// File: doc/tcp_client_sender.md
Name: tcp_client_sender

Overview:
- Active-open (initiator) TCP traffic source for the 100G TCP/IP stack; the client-side counterpart of the listening loopback server.
- On a start pulse it opens a session to a configured IP:port and streams cfg_pkt_count packets of deterministic payload through the stack's tx metadata/data/status interfaces.
- It then closes the session and reports done or error.
- Sits beside the workload kernels and drives the stack's open/close/tx ports directly.

Parameters:
OPEN_TIMEOUT, 32'd1000000, cycles to wait for open status before declaring error
RETRY_GAP, 16'd64, idle cycles before re-issuing tx metadata after a "no space" status

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; honoured only in IDLE
cfg_ip_addr  in  32  remote IPv4 address
cfg_port  in  16  remote TCP port
cfg_pkt_count  in  16  packets to send
cfg_pkt_words  in  10  64-byte beats per packet; 0 treated as 1
busy  out  1  high from accepted start until DONE/ERROR
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky until next accepted start
err_code  out  2  1=open fail, 2=open timeout, 3=tx no-connection
m_axis_open_connection_TVALID/TREADY/TDATA  out/in/out  1/1/48  [31:0] ip, [47:32] port
s_axis_open_status_TVALID/TREADY/TDATA  in/out/in  1/1/24  [15:0] session, [16] success
m_axis_close_connection_TVALID/TREADY/TDATA  out/in/out  1/1/16  session id
m_axis_tx_metadata_TVALID/TREADY/TDATA  out/in/out  1/1/32  [15:0] session, [31:16] length bytes
s_axis_tx_status_TVALID/TREADY/TDATA  in/out/in  1/1/64  [15:0] session, [31:16] length, [61:32] space, [63:62] error
m_axis_tx_data_TVALID/TREADY/TDATA/TKEEP/TLAST  out/in/out/out/out  1/1/512/64/1  payload stream

Behaviour:
- Reset: FSM=IDLE; all TVALID=0; busy=0; done=0; error=0; err_code=0; counters=0. rst mid-operation abandons the session without issuing close.
- s_axis_open_status_TREADY=1 only in OPEN_WAIT; s_axis_tx_status_TREADY=1 only in STATUS_WAIT; all other slave readys 0.
- Every master TVALID is registered and stays high with TDATA stable until the TVALID&&TREADY cycle; it deasserts the following cycle unless the next beat is ready.
- IDLE: on start, latch cfg_* (pkt_words 0 -> 1), clear error/err_code, set busy; go to OPEN_REQ.
- OPEN_REQ: assert open_connection with the latched ip/port; on handshake go to OPEN_WAIT and clear the timeout counter.
- OPEN_WAIT:
  - Status with success=1: latch session; go to META, or to CLOSE if pkt_count==0.
  - Status with success=0: go to ERROR, err_code=1.
  - Counter reaching OPEN_TIMEOUT: go to ERROR, err_code=2.
  - A status arriving on the timeout cycle wins.
- META: assert tx_metadata {pkt_words<<6, session}; on handshake go to STATUS_WAIT.
- STATUS_WAIT: on a status beat, action depends on the error field:
  - 0: go to DATA with beat counter=0.
  - 2 (no space): wait RETRY_GAP cycles, then return to META with an identical packet.
  - 1 or 3: go to ERROR, err_code=3; no close issued.
- DATA:
  - Each beat's TDATA = 16 copies of the 32-bit global beat index, which starts at 0 on start and increments per accepted beat across packets.
  - TKEEP = all ones.
  - TLAST=1 on beat pkt_words-1.
  - On the last-beat handshake, increment the packet counter. If count reached, go to CLOSE; else go to META.
  - Back-to-back beats are required: with TREADY held high, one beat per cycle.
- CLOSE: assert close_connection with session; on handshake go to DONE.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- ERROR: set error, clear busy, deassert all TVALIDs, return to IDLE next cycle.
- start outside IDLE is ignored.

Test Plan:
- Happy path: start with ip 0x0A000002, port 2888, count 2, words 3, stack always ready; open status {success=1, session 0x0007}. Required: open TDATA 0x0B480A000002; two metadata beats 0x00C00007; 6 data beats with indices 0..5 and TLAST on beats 2 and 5; close TDATA 0x0007; one done pulse.
- Open refused: open status success=0 -> error=1, err_code=1, no metadata, busy low.
- Open timeout (OPEN_TIMEOUT overridden to 100): no status -> ERROR exactly 100 cycles after entering OPEN_WAIT, err_code=2.
- No space: first tx status error=2 -> metadata re-issued exactly RETRY_GAP cycles later; second status error=0 -> data proceeds; total data beats unchanged.
- Backpressure: tx_data TREADY toggles randomly -> no beat lost or duplicated, TDATA stable while stalled, indices contiguous.
- Edge configs: count=0 -> open then close, no metadata. words=0 -> length 64 and a single TLAST beat. rst asserted in DATA -> all outputs return to reset values immediately.
